mont_exp_arbiter: RTL and testbench

Shares one `montgomery_Exponential` core between `N_REQ` requesters, such as the ARM command path and an on-chip self-test source. Requesters share one key (`m`, `R2 mod m`, `R mod m`, held in the wrapper registers); each request carries its own `x`, `e` and `e_width`. The block:
- arbitrates round-robin and latches operands;
- clears the core, pulses start and waits for done;
- returns the result with the requester id over a valid/ready response port.

---
 rtl/mont_exp_arbiter_pkg.sv | 17 +
 rtl/mont_exp_arbiter_if.sv | 33 +++
 rtl/mont_exp_arbiter_rr_arbiter.sv | 31 +++
 rtl/mont_exp_arbiter.sv | 128 ++++++++++++
 tb/tb_mont_exp_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_exp_arbiter_pkg.sv
// Shared types and constants for the Montgomery exponentiation arbiter.
// Holds the FSM state enum, the default exponent-width field and the cycle-counter limits.
package mont_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_BUSY,
      S_RESP
   } arb_state_e;

   localparam int EW_DEF = 12;
   localparam int CNT_W = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mont_exp_arbiter_if.sv
// Requester/response bundle between the arbiter and its clients.
// The master side issues requests and consumes responses; the arbiter is the slave.
interface mont_exp_arbiter_if
   import mont_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = 1024,
   parameter int EW = EW_DEF
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ*WIDTH-1:0] req_x;
   logic [N_REQ*WIDTH-1:0] req_e;
   logic [N_REQ*EW-1:0] req_e_width;
   logic rsp_valid;
   logic rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic rsp_err;

   modport master (
      output req_valid, req_x, req_e, req_e_width, rsp_ready,
      input req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
   );

   modport slave (
      input req_valid, req_x, req_e, req_e_width, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
   );

endinterface

// File: rtl/mont_exp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last+1 (mod N).
// The last-grant pointer register is owned by the caller.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input logic [N-1:0] req,
   input logic [IW-1:0] last,
   output logic [N-1:0] gnt,
   output logic [IW-1:0] idx,
   output logic any
);

   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (!any && req[j]) begin
            any = 1'b1;
            gnt[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/mont_exp_arbiter.sv
// Shares one Montgomery exponentiation core between N_REQ requesters (round-robin).
// Define MONT_ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYCLES).
module mont_exp_arbiter
   import mont_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = 1024,
   parameter int EW = EW_DEF,
   parameter int TIMEOUT_CYCLES = 1 << 22
) (
   input logic clk,
   input logic reset,
   mont_exp_arbiter_if.slave bus,
   output logic core_clear,
   output logic core_start,
   output logic [WIDTH-1:0] core_x,
   output logic [WIDTH-1:0] core_e,
   output logic [EW-1:0] core_e_width,
   input logic [WIDTH-1:0] core_result,
   input logic core_done,
   output logic [CNT_W-1:0] exp_cycles
);

   localparam int IDW = $clog2(N_REQ);

   arb_state_e state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] gidx;
   logic [N_REQ-1:0] gnt;
   logic any;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDW-1:0] id_q;
   logic [WIDTH-1:0] res_q;
   logic err_q;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_e;
   logic [EW-1:0] sel_ew;
   logic tmo_hit;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req(bus.req_valid),
      .last(last_grant),
      .gnt(gnt),
      .idx(gidx),
      .any(any)
   );

   always_comb begin
      sel_x = bus.req_x[int'(gidx)*WIDTH +: WIDTH];
      sel_e = bus.req_e[int'(gidx)*WIDTH +: WIDTH];
      sel_ew = bus.req_e_width[int'(gidx)*EW +: EW];
      cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   end

`ifdef MONT_ARB_TIMEOUT_EN
   assign tmo_hit = (state == S_BUSY) && !core_done
                    && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   // Grants are visible only while idle; reset forces them low at once.
   assign bus.req_ready = (state == S_IDLE && !reset) ? gnt : '0;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_id = id_q;
   assign bus.rsp_result = res_q;
   assign bus.rsp_err = err_q;
   assign core_clear = (state == S_CLEAR) || tmo_hit;
   assign core_start = (state == S_START);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         last_grant <= IDW'(N_REQ - 1);
         cnt <= '0;
         core_x <= '0;
         core_e <= '0;
         core_e_width <= '0;
         id_q <= '0;
         res_q <= '0;
         err_q <= 1'b0;
         exp_cycles <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (any) begin
                  core_x <= sel_x;
                  core_e <= sel_e;
                  core_e_width <= sel_ew;
                  id_q <= gidx;
                  last_grant <= gidx;
                  cnt <= '0;
                  err_q <= 1'b0;
                  if (sel_ew == '0) begin
                     res_q <= WIDTH'(1);
                     state <= S_RESP;
                  end else begin
                     state <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: state <= S_START;
            S_START: state <= S_BUSY;
            S_BUSY: begin
               cnt <= cnt_inc;
               if (core_done) begin
                  res_q <= core_result;
                  exp_cycles <= cnt_inc;
                  state <= S_RESP;
               end else if (tmo_hit) begin
                  res_q <= '0;
                  err_q <= 1'b1;
                  exp_cycles <= cnt_inc;
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_exp_arbiter.sv
// Self-checking bench for mont_exp_arbiter with a behavioural core model.
// Watchdog scenario is compiled only when MONT_ARB_TIMEOUT_EN is defined.
module tb_mont_exp_arbiter;

   localparam int NR = 2;
   localparam int W = 64;
   localparam int EWB = 12;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic core_clear;
   logic core_start;
   logic [W-1:0] core_x;
   logic [W-1:0] core_e;
   logic [EWB-1:0] core_e_width;
   logic [W-1:0] core_result = '0;
   logic core_done = 1'b0;
   logic [31:0] exp_cycles;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mont_exp_arbiter_if #(.N_REQ(NR), .WIDTH(W), .EW(EWB)) bus ();

   mont_exp_arbiter #(
      .N_REQ(NR),
      .WIDTH(W),
      .EW(EWB),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .core_clear(core_clear),
      .core_start(core_start),
      .core_x(core_x),
      .core_e(core_e),
      .core_e_width(core_e_width),
      .core_result(core_result),
      .core_done(core_done),
      .exp_cycles(exp_cycles)
   );

   function automatic logic [W-1:0] core_fn(input logic [W-1:0] x,
                                            input logic [W-1:0] e,
                                            input logic [EWB-1:0] ew);
      return (x ^ (e << 1)) + {52'b0, ew};
   endfunction

   // Core model: done rises in the mdl_lat-th cycle after the start pulse.
   int mdl_lat = 1;
   bit mdl_never = 1'b0;
   bit mdl_fix_en = 1'b0;
   logic [W-1:0] mdl_fix = '0;
   int rem = 0;

   always @(negedge clk) begin
      if (core_start) begin
         rem = mdl_lat + 1;
         core_result = mdl_fix_en ? mdl_fix : core_fn(core_x, core_e, core_e_width);
      end else if (rem > 0) begin
         rem--;
      end
      core_done = !mdl_never && (rem == 1);
   end

   // Reference state: round-robin pointer, operands, last exp_cycles.
   int ref_last = NR - 1;
   logic [63:0] ref_exp = '0;
   logic [W-1:0] rx [NR];
   logic [W-1:0] re [NR];
   logic [EWB-1:0] rew [NR];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ref_grant(input logic [NR-1:0] m);
      for (int k = 1; k <= NR; k++) begin
         int j;
         j = (ref_last + k) % NR;
         if (m[j]) return j;
      end
      return 0;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NR; i++) begin
         bus.req_x[i*W +: W] = rx[i];
         bus.req_e[i*W +: W] = re[i];
         bus.req_e_width[i*EWB +: EWB] = rew[i];
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 64'(bus.req_ready), 0);
      chk({tag, "_rvalid"}, 64'(bus.rsp_valid), 0);
      chk({tag, "_rid"}, 64'(bus.rsp_id), 0);
      chk({tag, "_rres"}, bus.rsp_result, 0);
      chk({tag, "_rerr"}, 64'(bus.rsp_err), 0);
      chk({tag, "_clr"}, 64'(core_clear), 0);
      chk({tag, "_start"}, 64'(core_start), 0);
      chk({tag, "_cx"}, core_x, 0);
      chk({tag, "_ce"}, core_e, 0);
      chk({tag, "_cew"}, 64'(core_e_width), 0);
      chk({tag, "_expc"}, 64'(exp_cycles), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      #1;
      check_zero("rst");
      @(negedge clk);
      reset = 1'b0;
      ref_last = NR - 1;
      ref_exp = '0;
   endtask

   // One transaction from an idle DUT through the response handshake.
   task automatic txn(input logic [NR-1:0] m, input int lat,
                      input int hold, input bit tmo);
      int g;
      int seen;
      logic [W-1:0] want;
      drive_ops();
      mdl_lat = lat;
      bus.req_valid = m;
      g = ref_grant(m);
      #1;
      chk("req_ready", 64'(bus.req_ready), 64'(1) << g);
      @(negedge clk);
      ref_last = g;
      chk("core_x", core_x, rx[g]);
      chk("core_e", core_e, re[g]);
      chk("core_ew", 64'(core_e_width), 64'(rew[g]));
      chk("ready_off", 64'(bus.req_ready), 0);
      if (rew[g] == '0) begin
         want = 1;
         chk("clr_ew0", 64'(core_clear), 0);
      end else begin
         chk("clear", 64'(core_clear), 1);
         @(negedge clk);
         chk("start", 64'(core_start), 1);
         chk("clr_off", 64'(core_clear), 0);
         seen = 0;
         for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
               seen = k;
               break;
            end
            chk("busy_clr", 64'(core_clear), 64'(tmo && k == TMO));
            chk("busy_ready", 64'(bus.req_ready), 0);
         end
         chk("rsp_lat", 64'(seen), 64'(lat + 1));
         if (tmo) want = '0;
         else want = mdl_fix_en ? mdl_fix : core_fn(rx[g], re[g], rew[g]);
         ref_exp = 64'(lat);
      end
      chk("rsp_valid", 64'(bus.rsp_valid), 1);
      chk("rsp_id", 64'(bus.rsp_id), 64'(g));
      chk("rsp_result", bus.rsp_result, want);
      chk("rsp_err", 64'(bus.rsp_err), 64'(tmo));
      chk("exp_cycles", 64'(exp_cycles), ref_exp);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("hold_valid", 64'(bus.rsp_valid), 1);
         chk("hold_id", 64'(bus.rsp_id), 64'(g));
         chk("hold_res", bus.rsp_result, want);
         chk("hold_ready", 64'(bus.req_ready), 0);
         chk("hold_start", 64'(core_start), 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", 64'(bus.rsp_valid), 0);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_x = '0;
      bus.req_e = '0;
      bus.req_e_width = '0;
      bus.rsp_ready = 1'b0;
      do_reset();

      // single request with a fixed core result
      rx[0] = 5; re[0] = 3; rew[0] = 2;
      rx[1] = 0; re[1] = 0; rew[1] = 1;
      mdl_fix_en = 1'b1;
      mdl_fix = 64'h7D;
      txn(2'b01, 10, 0, 1'b0);
      mdl_fix_en = 1'b0;

      // round-robin from reset
      do_reset();
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < NR; i++) begin
            rx[i] = {$urandom, $urandom};
            re[i] = {$urandom, $urandom};
            rew[i] = 12'($urandom_range(1, 4095));
         end
         txn(2'b11, $urandom_range(1, 6), 0, 1'b0);
      end

      // zero exponent width
      rew[1] = '0;
      txn(2'b10, 3, 2, 1'b0);

      // back-pressure with req1 pending, then immediate next accept
      rew[1] = 12'd9;
      txn(2'b10, 5, 20, 1'b0);
      txn(2'b10, 4, 0, 1'b0);

      // reset five cycles into BUSY
      do_reset();
      rx[0] = {$urandom, $urandom};
      rew[0] = 12'd5;
      drive_ops();
      mdl_lat = 30;
      bus.req_valid = 2'b01;
      @(negedge clk);
      @(negedge clk);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check_zero("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = '0;
      ref_last = NR - 1;
      ref_exp = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("late_done_rsp", 64'(bus.rsp_valid), 0);
         chk("late_done_start", 64'(core_start), 0);
      end
      rew[1] = 12'd3;
      txn(2'b11, 6, 0, 1'b0);

`ifdef MONT_ARB_TIMEOUT_EN
      mdl_never = 1'b1;
      rew[0] = 12'd7;
      rew[1] = 12'd7;
      txn(2'b11, TMO, 2, 1'b1);
      mdl_never = 1'b0;
`endif

      // randomized traffic
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < NR; i++) begin
            rx[i] = {$urandom, $urandom};
            re[i] = {$urandom, $urandom};
            rew[i] = ($urandom_range(0, 3) == 0) ? '0
                     : 12'($urandom_range(1, 4095));
         end
         txn(2'($urandom_range(1, 3)), $urandom_range(1, 12),
             $urandom_range(0, 3), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
